// File: rtl/pwm_output_stage_if.sv
// Bundle between the drive controller and the PWM output stage: command strobe
// and enable in one direction, bridge pins and status in the other.
interface pwm_output_stage_if #(
    parameter int CMD_W  = 12,
    parameter int DUTY_W = 12
);
    logic                    enable_i;
    logic signed [CMD_W-1:0] cmd_i;
    logic                    cmd_valid_i;
    logic                    pwm_o;
    logic                    direction_o;
    logic                    period_start_o;
    logic                    deadtime_o;
    logic [DUTY_W-1:0]       duty_o;

    modport master (
        output enable_i, cmd_i, cmd_valid_i,
        input  pwm_o, direction_o, period_start_o, deadtime_o, duty_o
    );

    modport slave (
        input  enable_i, cmd_i, cmd_valid_i,
        output pwm_o, direction_o, period_start_o, deadtime_o, duty_o
    );
endinterface

// File: rtl/pwm_output_stage.sv
// H-bridge PWM output stage: signed effort -> period-synchronous duty, direction
// and dead-time blanking on reversal. Optional slew limiting: PWM_SOFTSTART_EN.
module pwm_output_stage #(
    parameter int PERIOD_CYCLES    = 2500,
    parameter int CMD_W            = 12,
    parameter int DEADTIME_PERIODS = 2,
    parameter int SLEW_STEP        = 64
) (
    input  logic              clk_i,
    input  logic              nReset_i,
    pwm_output_stage_if.slave bus
);
    localparam int DUTY_W = $clog2(PERIOD_CYCLES + 1);
    localparam int MAG_W  = CMD_W - 1;
    localparam int PROD_W = MAG_W + DUTY_W;

    localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(PERIOD_CYCLES - 1);
    localparam logic [DUTY_W-1:0] FULL_CMP = DUTY_W'(PERIOD_CYCLES);
    localparam logic [MAG_W-1:0]  MAG_MAX  = '1;
    localparam logic [3:0]        DT_LOAD  = 4'(DEADTIME_PERIODS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEADTIME} state_t;

    function automatic logic [MAG_W-1:0] f_mag(input logic signed [CMD_W-1:0] c);
        logic [CMD_W-1:0] a;
        a = c[CMD_W-1] ? (~c + 1'b1) : c;
        // Only the most negative code leaves the top bit set after negation.
        f_mag = a[CMD_W-1] ? MAG_MAX : a[MAG_W-1:0];
    endfunction

    function automatic logic [DUTY_W-1:0] f_compare(input logic [MAG_W-1:0] m);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(m) * PROD_W'(PERIOD_CYCLES);
        prod = prod >> MAG_W;
        f_compare = (m == MAG_MAX) ? FULL_CMP : prod[DUTY_W-1:0];
    endfunction

`ifdef PWM_SOFTSTART_EN
    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(SLEW_STEP);

    function automatic logic [DUTY_W-1:0] f_slew(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] tgt);
        if (tgt > cur)
            f_slew = ((tgt - cur) > STEP) ? (cur + STEP) : tgt;
        else
            f_slew = ((cur - tgt) > STEP) ? (cur - STEP) : tgt;
    endfunction
`endif

    state_t                  r_state, w_state_nx;
    logic [DUTY_W-1:0]       r_cnt, w_cnt_nx;
    logic [DUTY_W-1:0]       r_cmp, w_cmp_nx;
    logic                    r_dir, w_dir_nx;
    logic [3:0]              r_dt, w_dt_nx;
    logic signed [CMD_W-1:0] r_pend;
    logic                    r_pwm, w_pwm_nx;

    logic signed [CMD_W-1:0] w_pend;
    logic [DUTY_W-1:0]       w_tgt_cmp;
    logic [DUTY_W-1:0]       w_stepped;
    logic [DUTY_W-1:0]       w_cnt_inc;
    logic                    w_pos, w_neg, w_oppose, w_wrap;

    // A strobe coinciding with the boundary bypasses straight into the apply path.
    assign w_pend    = bus.cmd_valid_i ? bus.cmd_i : r_pend;
    assign w_tgt_cmp = f_compare(f_mag(w_pend));
    assign w_neg     = w_pend[CMD_W-1];
    assign w_pos     = !w_pend[CMD_W-1] && (w_pend != '0);
    assign w_oppose  = (w_neg && r_dir) || (w_pos && !r_dir);
    assign w_wrap    = (r_cnt == LAST_CNT);
    assign w_cnt_inc = w_wrap ? '0 : (r_cnt + 1'b1);

    always_comb begin
`ifdef PWM_SOFTSTART_EN
        w_stepped = f_slew(r_cmp, w_tgt_cmp);
`else
        w_stepped = w_tgt_cmp;
`endif
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cmp_nx   = r_cmp;
        w_dir_nx   = r_dir;
        w_dt_nx    = r_dt;
        if (!bus.enable_i) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
            w_cmp_nx   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Bridge has been off, so a reversal here needs no blanking.
                    w_state_nx = S_RUN;
                    w_cnt_nx   = '0;
                    w_cmp_nx   = w_stepped;
                    if (w_oppose) w_dir_nx = !r_dir;
                end
                S_RUN: begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_wrap) begin
                        if (w_oppose) begin
                            w_state_nx = S_DEADTIME;
                            w_cmp_nx   = '0;
                            w_dt_nx    = DT_LOAD;
                        end else begin
                            w_cmp_nx = w_stepped;
                        end
                    end
                end
                S_DEADTIME: begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_wrap) begin
                        w_dt_nx = r_dt - 1'b1;
                        if (r_dt == 4'd1) begin
                            w_state_nx = S_RUN;
                            w_cmp_nx   = w_stepped;
                            if (w_oppose) w_dir_nx = !r_dir;
                        end
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
        w_pwm_nx = bus.enable_i && (r_state != S_IDLE) && (r_cnt < r_cmp);
    end

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cmp   <= '0;
            r_dir   <= 1'b1;
            r_dt    <= '0;
            r_pend  <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cmp   <= w_cmp_nx;
            r_dir   <= w_dir_nx;
            r_dt    <= w_dt_nx;
            r_pwm   <= w_pwm_nx;
            if (bus.cmd_valid_i) r_pend <= bus.cmd_i;
        end
    end

    assign bus.pwm_o          = r_pwm;
    assign bus.direction_o    = r_dir;
    assign bus.period_start_o = (r_state != S_IDLE) && (r_cnt == '0);
    assign bus.deadtime_o     = (r_state == S_DEADTIME);
    assign bus.duty_o         = r_cmp;
endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench for pwm_output_stage: duty, direction, dead time, enable and reset.
module tb_pwm_output_stage;
    localparam int P     = 2500;
    localparam int CMD_W = 12;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int total = 0;
    int bad = 0;
    int m_cmp = 0;

    pwm_output_stage_if #(.CMD_W(CMD_W), .DUTY_W(12)) bus ();

    pwm_output_stage #(
        .PERIOD_CYCLES(P), .CMD_W(CMD_W), .DEADTIME_PERIODS(2), .SLEW_STEP(64)
    ) dut (
        .clk_i(clk),
        .nReset_i(nrst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: |cmd| saturated to full scale, full scale -> whole period.
    function automatic int ref_compare(int cmd);
        int m;
        m = (cmd < 0) ? -cmd : cmd;
        if (m > 2047) m = 2047;
        if (m == 2047) return P;
        return (m * P) / 2048;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe(int cmd);
        bus.cmd_i       = CMD_W'(cmd);
        bus.cmd_valid_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_start(string tag);
        int n = 0;
        while (!bus.period_start_o && n < 3 * P) begin
            tick();
            n++;
        end
        if (!bus.period_start_o) begin
            bad++;
            total++;
            $display("FAIL %s: no period start within %0d cycles", tag, n);
        end
    endtask

    task automatic measure(output int highs, output int starts);
        highs = 0;
        starts = 0;
        repeat (P) begin
            tick();
            highs  += int'(bus.pwm_o);
            starts += int'(bus.period_start_o);
        end
    endtask

    task automatic test_reset();
        bus.enable_i = 1'b0; bus.cmd_valid_i = 1'b0; bus.cmd_i = '0;
        nrst = 1'b0;
        repeat (3) tick();
        total++; if (bus.pwm_o !== 1'b0) begin bad++; $display("FAIL reset_pwm: got %b want 0", bus.pwm_o); end
        total++; if (bus.direction_o !== 1'b1) begin bad++; $display("FAIL reset_dir: got %b want 1", bus.direction_o); end
        total++; if (bus.period_start_o !== 1'b0) begin bad++; $display("FAIL reset_ps: got %b want 0", bus.period_start_o); end
        total++; if (bus.deadtime_o !== 1'b0) begin bad++; $display("FAIL reset_dt: got %b want 0", bus.deadtime_o); end
        total++; if (bus.duty_o !== 12'd0) begin bad++; $display("FAIL reset_duty: got %0d want 0", bus.duty_o); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int h, s;
        bus.enable_i = 1'b1;
        strobe(1024);
        m_cmp = ref_compare(1024);
        total++; if (bus.period_start_o !== 1'b1) begin bad++; $display("FAIL basic_first_ps: got %b want 1", bus.period_start_o); end
        total++; if (int'(bus.duty_o) != m_cmp) begin bad++; $display("FAIL basic_duty: got %0d want %0d", bus.duty_o, m_cmp); end
        total++; if (bus.direction_o !== 1'b1) begin bad++; $display("FAIL basic_dir: got %b want 1", bus.direction_o); end
        for (int i = 0; i < 2; i++) begin
            measure(h, s);
            total++; if (h != 1250) begin bad++; $display("FAIL basic_highs: got %0d want 1250", h); end
            total++; if (s != 1) begin bad++; $display("FAIL basic_starts: got %0d want 1", s); end
        end
    endtask

    task automatic test_midperiod_update();
        int h, s, changed;
        wait_start("mid_sync");
        repeat (100) tick();
        strobe(500);
        changed = 0;
        for (int n = 0; n < 3 * P && !bus.period_start_o; n++) begin
            if (int'(bus.duty_o) != m_cmp) changed++;
            tick();
        end
        total++; if (changed != 0) begin bad++; $display("FAIL mid_hold: duty changed on %0d cycles want 0", changed); end
        m_cmp = ref_compare(500);
        total++; if (int'(bus.duty_o) != 610 || m_cmp != 610) begin bad++; $display("FAIL mid_duty: got %0d want 610", bus.duty_o); end
        measure(h, s);
        total++; if (h != 610) begin bad++; $display("FAIL mid_highs: got %0d want 610", h); end
    endtask

    task automatic test_random();
        int h, s, cmd, k;
        for (int it = 0; it < 5; it++) begin
            cmd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2047));
            k = (it == 0) ? P - 1 : int'($urandom_range(0, P - 1));
            wait_start("rnd_sync");
            repeat (k) tick();
            strobe(cmd);
            wait_start("rnd_apply");
            m_cmp = ref_compare(cmd);
            total++; if (int'(bus.duty_o) != m_cmp) begin bad++; $display("FAIL rnd_duty: cmd %0d got %0d want %0d", cmd, bus.duty_o, m_cmp); end
            total++; if (bus.direction_o !== 1'b1) begin bad++; $display("FAIL rnd_dir: cmd %0d got %b want 1", cmd, bus.direction_o); end
            measure(h, s);
            total++; if (h != m_cmp) begin bad++; $display("FAIL rnd_highs: cmd %0d got %0d want %0d", cmd, h, m_cmp); end
        end
    endtask

    task automatic test_reverse();
        int h, s, dtc, low;
        strobe(2047);
        wait_start("rev_full");
        total++; if (bus.duty_o !== 12'd2500) begin bad++; $display("FAIL rev_full_duty: got %0d want 2500", bus.duty_o); end
        measure(h, s);
        total++; if (h != P) begin bad++; $display("FAIL rev_full_highs: got %0d want %0d", h, P); end
        strobe(-2048);
        wait_start("rev_enter");
        total++; if (bus.deadtime_o !== 1'b1) begin bad++; $display("FAIL rev_dt_enter: got %b want 1", bus.deadtime_o); end
        total++; if (bus.direction_o !== 1'b1) begin bad++; $display("FAIL rev_dir_hold: got %b want 1", bus.direction_o); end
        dtc = 0; low = 0;
        for (int i = 0; i < 6000; i++) begin
            dtc += int'(bus.deadtime_o);
            low += int'(!bus.pwm_o);
            tick();
            if (bus.pwm_o && low > 0) break;
        end
        total++; if (dtc != 2 * P) begin bad++; $display("FAIL rev_dt_len: got %0d want %0d", dtc, 2 * P); end
        total++; if (low != 2 * P) begin bad++; $display("FAIL rev_low_len: got %0d want %0d", low, 2 * P); end
        total++; if (bus.direction_o !== 1'b0) begin bad++; $display("FAIL rev_dir: got %b want 0", bus.direction_o); end
        m_cmp = ref_compare(-2048);
        total++; if (int'(bus.duty_o) != m_cmp) begin bad++; $display("FAIL rev_duty: got %0d want %0d", bus.duty_o, m_cmp); end
        wait_start("rev_run");
        measure(h, s);
        total++; if (h != P) begin bad++; $display("FAIL rev_highs: got %0d want %0d", h, P); end
    endtask

    task automatic test_zero_cmd();
        int h, s;
        strobe(0);
        wait_start("zero_apply");
        total++; if (bus.deadtime_o !== 1'b0) begin bad++; $display("FAIL zero_dt: got %b want 0", bus.deadtime_o); end
        total++; if (bus.duty_o !== 12'd0) begin bad++; $display("FAIL zero_duty: got %0d want 0", bus.duty_o); end
        measure(h, s);
        total++; if (h != 0) begin bad++; $display("FAIL zero_highs: got %0d want 0", h); end
        total++; if (bus.direction_o !== 1'b0) begin bad++; $display("FAIL zero_dir: got %b want 0", bus.direction_o); end
        m_cmp = 0;
    endtask

    task automatic test_disable_in_deadtime();
        int h, s;
        strobe(1000);
        wait_start("dis_enter");
        total++; if (bus.deadtime_o !== 1'b1) begin bad++; $display("FAIL dis_dt_enter: got %b want 1", bus.deadtime_o); end
        repeat (37) tick();
        bus.enable_i = 1'b0;
        tick();
        total++; if (bus.pwm_o !== 1'b0) begin bad++; $display("FAIL dis_pwm: got %b want 0", bus.pwm_o); end
        total++; if (bus.deadtime_o !== 1'b0) begin bad++; $display("FAIL dis_dt: got %b want 0", bus.deadtime_o); end
        repeat (20) tick();
        strobe(-200);
        total++; if (bus.period_start_o !== 1'b0) begin bad++; $display("FAIL dis_idle_ps: got %b want 0", bus.period_start_o); end
        bus.enable_i = 1'b1;
        tick();
        m_cmp = ref_compare(-200);
        total++; if (bus.direction_o !== 1'b0) begin bad++; $display("FAIL reen_dir: got %b want 0", bus.direction_o); end
        total++; if (bus.deadtime_o !== 1'b0) begin bad++; $display("FAIL reen_dt: got %b want 0", bus.deadtime_o); end
        total++; if (int'(bus.duty_o) != 244 || m_cmp != 244) begin bad++; $display("FAIL reen_duty: got %0d want 244", bus.duty_o); end
        total++; if (bus.period_start_o !== 1'b1) begin bad++; $display("FAIL reen_ps: got %b want 1", bus.period_start_o); end
        measure(h, s);
        total++; if (h != 244) begin bad++; $display("FAIL reen_highs: got %0d want 244", h); end
    endtask

    task automatic test_reset_midrun();
        int h;
        repeat (100) tick();
        total++; if (bus.pwm_o !== 1'b1) begin bad++; $display("FAIL rst_pre_pwm: got %b want 1", bus.pwm_o); end
        nrst = 1'b0;
        #1;
        total++; if (bus.pwm_o !== 1'b0) begin bad++; $display("FAIL rst_pwm: got %b want 0", bus.pwm_o); end
        total++; if (bus.direction_o !== 1'b1) begin bad++; $display("FAIL rst_dir: got %b want 1", bus.direction_o); end
        total++; if (bus.duty_o !== 12'd0) begin bad++; $display("FAIL rst_duty: got %0d want 0", bus.duty_o); end
        total++; if (bus.period_start_o !== 1'b0 || bus.deadtime_o !== 1'b0) begin bad++; $display("FAIL rst_flags: got ps=%b dt=%b want 0 0", bus.period_start_o, bus.deadtime_o); end
        tick();
        nrst = 1'b1;
        h = 0;
        repeat (50) begin tick(); h += int'(bus.pwm_o); end
        total++; if (h != 0) begin bad++; $display("FAIL rst_release_pulse: got %0d high cycles want 0", h); end
    endtask

    task automatic test_idle_flip();
        int h, s;
        bus.enable_i = 1'b0;
        tick();
        strobe(-300);
        bus.enable_i = 1'b1;
        tick();
        m_cmp = ref_compare(-300);
        total++; if (bus.direction_o !== 1'b0) begin bad++; $display("FAIL flip_dir: got %b want 0", bus.direction_o); end
        total++; if (bus.deadtime_o !== 1'b0) begin bad++; $display("FAIL flip_dt: got %b want 0", bus.deadtime_o); end
        total++; if (int'(bus.duty_o) != m_cmp) begin bad++; $display("FAIL flip_duty: got %0d want %0d", bus.duty_o, m_cmp); end
        measure(h, s);
        total++; if (h != m_cmp) begin bad++; $display("FAIL flip_highs: got %0d want %0d", h, m_cmp); end
    endtask

    initial begin
        bus.enable_i = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i = '0;
        test_reset();
        test_basic();
        test_midperiod_update();
        test_random();
        test_reverse();
        test_zero_cmd();
        test_disable_in_deadtime();
        test_reset_midrun();
        test_idle_flip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
